// File: rtl/bdi_pkg.sv
// Shared constants and encoding helpers for the BDI decompressor.
package bdi_pkg;

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned CHUNK_W    = 64;
  localparam int unsigned NUM_CHUNKS = LINE_W / CHUNK_W;

  localparam logic [3:0] ENC_ZEROS   = 4'd0;
  localparam logic [3:0] ENC_REPEAT8 = 4'd1;
  localparam logic [3:0] ENC_B8D1    = 4'd2;
  localparam logic [3:0] ENC_B8D2    = 4'd3;
  localparam logic [3:0] ENC_B8D4    = 4'd4;
  localparam logic [3:0] ENC_B4D1    = 4'd5;
  localparam logic [3:0] ENC_B4D2    = 4'd6;
  localparam logic [3:0] ENC_B2D1    = 4'd7;
  localparam logic [3:0] ENC_UNCOMP  = 4'd15;

  function automatic logic [3:0] base_bytes(input logic [3:0] enc);
    case (enc)
      ENC_B8D1, ENC_B8D2, ENC_B8D4: base_bytes = 4'd8;
      ENC_B4D1, ENC_B4D2:           base_bytes = 4'd4;
      ENC_B2D1:                     base_bytes = 4'd2;
      default:                      base_bytes = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] delta_bytes(input logic [3:0] enc);
    case (enc)
      ENC_B8D1, ENC_B4D1, ENC_B2D1: delta_bytes = 3'd1;
      ENC_B8D2, ENC_B4D2:           delta_bytes = 3'd2;
      ENC_B8D4:                     delta_bytes = 3'd4;
      default:                      delta_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_delta_enc(input logic [3:0] enc);
    is_delta_enc = (enc >= ENC_B8D1) && (enc <= ENC_B2D1);
  endfunction

endpackage

// File: rtl/bdi_chunk_expand.sv
// Combinational rebuild of one 64-bit chunk of a base+delta encoded line.
module bdi_chunk_expand
  import bdi_pkg::*;
(
  input  logic [3:0]         enc_i,
  input  logic [LINE_W-1:0]  payload_i,
  input  logic [1:0]         chunk_idx_i,
  output logic [CHUNK_W-1:0] chunk_o
);

  function automatic logic [63:0] sext(input logic [31:0] raw, input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    sext = {{56{raw[7]}}, raw[7:0]};
      3'd2:    sext = {{48{raw[15]}}, raw[15:0]};
      3'd4:    sext = {{32{raw[31]}}, raw};
      default: sext = 64'h0;
    endcase
  endfunction

  logic [3:0]  bb;
  logic [2:0]  db;
  int unsigned ki;
  int unsigned widx;
  logic [7:0]  off;
  logic [63:0] dext;

  always_comb begin
    chunk_o = '0;
    bb      = base_bytes(enc_i);
    db      = delta_bytes(enc_i);
    ki      = 32'(chunk_idx_i);
    widx    = 0;
    off     = '0;
    dext    = '0;
    // Word index within the line picks the delta; base always sits at the bottom.
    case (bb)
      4'd8: begin
        widx    = ki;
        off     = 8'(64 + 8 * 32'(db) * widx);
        dext    = sext(payload_i[off +: 32], db);
        chunk_o = payload_i[63:0] + dext;
      end
      4'd4: begin
        for (int j = 0; j < 2; j++) begin
          widx = 2 * ki + 32'(j);
          off  = 8'(32 + 8 * 32'(db) * widx);
          dext = sext(payload_i[off +: 32], db);
          chunk_o[32*j +: 32] = payload_i[31:0] + dext[31:0];
        end
      end
      4'd2: begin
        for (int j = 0; j < 4; j++) begin
          widx = 4 * ki + 32'(j);
          off  = 8'(16 + 8 * 32'(db) * widx);
          dext = sext(payload_i[off +: 32], db);
          chunk_o[16*j +: 16] = payload_i[15:0] + dext[15:0];
        end
      end
      default: chunk_o = '0;
    endcase
  end

endmodule

// File: rtl/bdi_decompressor.sv
// BDI line decompressor: capture, expand delta lines one chunk per cycle, hand off.
module bdi_decompressor
  import bdi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_enc_i,
  input  logic [LINE_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LINE_W-1:0] out_line_o,
  output logic              out_err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [3:0]         enc_q, enc_d;
  logic [LINE_W-1:0]  data_q, data_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               err_q, err_d;
  logic [CHUNK_W-1:0] chunk;
  logic               accept;

  // Ready is masked by reset so it reads 0 while rst_n is held low.
  assign in_ready_o  = rst_n && (state_q == ST_IDLE);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == ST_DONE);
  assign out_line_o  = line_q;
  assign out_err_o   = err_q;

  bdi_chunk_expand u_expand (
    .enc_i       (enc_q),
    .payload_i   (data_q),
    .chunk_idx_i (k_q),
    .chunk_o     (chunk)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    enc_d   = enc_q;
    data_d  = data_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          enc_d  = in_enc_i;
          data_d = in_data_i;
          line_d = '0;
          err_d  = 1'b0;
          k_d    = 2'd0;
          if (is_delta_enc(in_enc_i)) begin
            state_d = ST_EXPAND;
          end else begin
            state_d = ST_DONE;
            case (in_enc_i)
              ENC_ZEROS:   line_d = '0;
              ENC_REPEAT8: line_d = {4{in_data_i[63:0]}};
              ENC_UNCOMP:  line_d = in_data_i;
              default:     err_d  = 1'b1;
            endcase
          end
        end
      end
      ST_EXPAND: begin
        line_d[CHUNK_W*k_q +: CHUNK_W] = chunk;
        if (k_q == 2'd3) begin
          k_d     = 2'd0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      enc_q   <= 4'd0;
      data_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      enc_q   <= enc_d;
      data_q  <= data_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bdi_decompressor.sv
// Directed-vector bench for bdi_decompressor with hand-computed expected lines.
module tb_bdi_decompressor;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_enc;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_line;
  logic         out_err;

  int n_chk;
  int n_err;

  bdi_decompressor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_enc_i    (in_enc),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_line_o  (out_line),
    .out_err_o   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] enc, input logic [255:0] data);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_enc   = enc;
    in_data  = data;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".vld_drop"}, 256'(out_valid), 256'd0);
    check({tag, ".rdy_back"}, 256'(in_ready), 256'd1);
  endtask

  task automatic run_line(input string tag, input logic [3:0] enc, input logic [255:0] data,
                          input logic [255:0] exp_line, input logic exp_err, input int exp_lat);
    int lat;
    send(enc, data);
    check({tag, ".busy"}, 256'(in_ready), 256'd0);
    wait_valid(lat);
    check({tag, ".lat"}, 256'(lat), 256'(exp_lat));
    check({tag, ".line"}, out_line, exp_line);
    check({tag, ".err"}, 256'(out_err), 256'(exp_err));
    handoff(tag);
  endtask

  logic [255:0] d, e;
  logic [15:0]  dl16 [8];
  logic [31:0]  ew32 [8];

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_enc    = 4'd0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    check("rst.rdy", 256'(in_ready), 256'd0);
    check("rst.vld", 256'(out_valid), 256'd0);
    check("rst.line", out_line, 256'd0);
    check("rst.err", 256'(out_err), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst.rdy_after", 256'(in_ready), 256'd1);

    run_line("b8d1", 4'd2, {160'h0, 32'hFF44_2200, 64'h22},
             {64'h21, 64'h66, 64'h44, 64'h22}, 1'b0, 5);

    run_line("b8d2", 4'd3, {128'h0, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 64'h10000},
             {64'h17FFF, 64'h8000, 64'hFFFF, 64'h10001}, 1'b0, 5);

    run_line("b8d4", 4'd4, {64'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 64'h1},
             {64'hFFFF_FFFF_8000_0001, 64'h8000_0000, 64'h0, 64'h1}, 1'b0, 5);

    run_line("b4d1", 4'd5, {160'h0, 64'hF010_0200_FF80_7F01, 32'h100},
             {32'hF0, 32'h110, 32'h102, 32'h100, 32'hFF, 32'h80, 32'h17F, 32'h101}, 1'b0, 5);

    // Carries into the upper half-word and negative 16-bit deltas.
    dl16 = '{16'h0000, 16'h0FFF, 16'h1000, 16'h2345, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hF000};
    ew32 = '{32'h0000_F000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_1345,
             32'h0001_6FFF, 32'h0000_7000, 32'h0000_EFFF, 32'h0000_E000};
    d = '0;
    e = '0;
    d[31:0] = 32'h0000_F000;
    for (int i = 0; i < 8; i++) begin
      d[32 + 16*i +: 16] = dl16[i];
      e[32*i +: 32]      = ew32[i];
    end
    run_line("b4d2", 4'd6, d, e, 1'b0, 5);

    d = '0;
    d[15:0] = 16'hFFF0;
    for (int i = 0; i < 16; i++) begin
      d[16 + 8*i +: 8] = 8'(i);
      e[16*i +: 16]    = 16'hFFF0 + 16'(i);
    end
    run_line("b2d1", 4'd7, d, e, 1'b0, 5);
    check("b2d1.w15", 256'(e[255:240]), 256'hFFFF);

    d[16 + 8*15 +: 8] = 8'h20;
    e[255:240]        = 16'h0010;
    run_line("b2d1_wrap", 4'd7, d, e, 1'b0, 5);

    run_line("zeros", 4'd0, {8{32'hA5A5_A5A5}}, 256'h0, 1'b0, 1);
    run_line("rep8", 4'd1, {64'h1, 64'h2, 64'h3, 64'hDEAD_BEEF_0011_2233},
             {4{64'hDEAD_BEEF_0011_2233}}, 1'b0, 1);
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    run_line("uncomp", 4'd15, d, d, 1'b0, 1);

    // Illegal encoding, then stall with stray in_valid pulses.
    begin
      int lat;
      send(4'd9, {8{32'h1234_5678}});
      wait_valid(lat);
      check("ill.lat", 256'(lat), 256'd1);
      for (int i = 0; i < 10; i++) begin
        in_valid = i[0];
        in_enc   = 4'd15;
        in_data  = {8{32'hCAFE_F00D}};
        @(posedge clk); #1;
        check("bp.vld", 256'(out_valid), 256'd1);
        check("bp.line", out_line, 256'd0);
        check("bp.err", 256'(out_err), 256'd1);
      end
      in_valid = 1'b0;
      handoff("bp");
    end
    run_line("after_err", 4'd1, {192'h0, 64'h0123_4567_89AB_CDEF},
             {4{64'h0123_4567_89AB_CDEF}}, 1'b0, 1);

    // Reset while chunk 2 is being rebuilt.
    send(4'd2, {160'h0, 32'hFF44_2200, 64'h22});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst.rdy", 256'(in_ready), 256'd0);
    check("mrst.vld", 256'(out_valid), 256'd0);
    check("mrst.line", out_line, 256'd0);
    check("mrst.err", 256'(out_err), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("mrst.no_emit", 256'(out_valid), 256'd0);
    end
    run_line("post_rst", 4'd2, {160'h0, 32'hFF44_2200, 64'h22},
             {64'h21, 64'h66, 64'h44, 64'h22}, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
